// File: rtl/wb_pipe_reg.sv
// Writeback pipeline register: LANES parallel lanes with intra-bundle write shadowing,
// a same-stage forwarding port, a retired-lane counter and a saturating consecutive-hold counter.
module wb_pipe_reg #(
    parameter int                 LANES      = 2,
    parameter int                 XLEN       = 32,
    parameter int                 REG_ADDR_W = 5,
    parameter int                 STALL_W    = 2,
    parameter int                 CNT_W      = 32,
    parameter int                 HCNT_W     = 8,
    parameter logic [STALL_W-1:0] PASS       = 2'b00,
    parameter logic [STALL_W-1:0] HOLD       = 2'b01,
    parameter logic [STALL_W-1:0] BUBB       = 2'b10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [STALL_W-1:0]           stall,
    input  logic                         flush,
    input  logic [LANES-1:0]             valid_i,
    input  logic [LANES*REG_ADDR_W-1:0]  rd_addr_i,
    input  logic [LANES-1:0]             rd_write_i,
    input  logic [LANES*XLEN-1:0]        rd_data_i,
    output logic [LANES-1:0]             valid_o,
    output logic [LANES*REG_ADDR_W-1:0]  rd_addr_o,
    output logic [LANES-1:0]             rd_write_o,
    output logic [LANES*XLEN-1:0]        rd_data_o,
    input  logic [REG_ADDR_W-1:0]        fwd_addr_i,
    output logic                         fwd_hit_o,
    output logic [XLEN-1:0]              fwd_data_o,
    output logic [CNT_W-1:0]             retire_cnt_o,
    output logic [HCNT_W-1:0]            hold_cnt_o
);

    logic                  w_pass;
    logic                  w_hold;
    logic                  w_bubb;
    logic [CNT_W-1:0]      w_pop;

    logic                  r_valid [LANES];
    logic [REG_ADDR_W-1:0] r_addr  [LANES];
    logic                  r_wr    [LANES];
    logic [XLEN-1:0]       r_data  [LANES];
    logic                  w_shadow [LANES];
    logic                  w_wr_nxt [LANES];

    logic [CNT_W-1:0]      r_retire;
    logic [HCNT_W-1:0]     r_hold;

    // flush outranks every stall code; unknown codes (2'b11) behave as bubbles
    assign w_pass = !flush && (stall == PASS);
    assign w_hold = !flush && (stall == HOLD);
    assign w_bubb = flush || (stall == BUBB) || ((stall != PASS) && (stall != HOLD));

    genvar l;
    generate
        for (l = 0; l < LANES; l++) begin : g_lane
            // a younger (higher) lane writing the same register makes this lane's write dead
            always_comb begin
                w_shadow[l] = 1'b0;
                for (int m = l + 1; m < LANES; m++) begin
                    if (valid_i[m] && rd_write_i[m] &&
                        (rd_addr_i[m*REG_ADDR_W +: REG_ADDR_W] == rd_addr_i[l*REG_ADDR_W +: REG_ADDR_W]))
                        w_shadow[l] = 1'b1;
                end
            end

            assign w_wr_nxt[l] = rd_write_i[l] && valid_i[l] &&
                                 (rd_addr_i[l*REG_ADDR_W +: REG_ADDR_W] != '0) && !w_shadow[l];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_valid[l] <= 1'b0;
                    r_addr[l]  <= '0;
                    r_wr[l]    <= 1'b0;
                    r_data[l]  <= '0;
                end else if (w_pass) begin
                    r_valid[l] <= valid_i[l];
                    r_addr[l]  <= rd_addr_i[l*REG_ADDR_W +: REG_ADDR_W];
                    r_wr[l]    <= w_wr_nxt[l];
                    r_data[l]  <= rd_data_i[l*XLEN +: XLEN];
                end else if (w_bubb) begin
                    r_valid[l] <= 1'b0;
                    r_addr[l]  <= '0;
                    r_wr[l]    <= 1'b0;
                    r_data[l]  <= '0;
                end
            end

            assign valid_o[l]                              = r_valid[l];
            assign rd_addr_o[l*REG_ADDR_W +: REG_ADDR_W]   = r_addr[l];
            assign rd_write_o[l]                           = r_wr[l];
            assign rd_data_o[l*XLEN +: XLEN]               = r_data[l];
        end
    endgenerate

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++)
            w_pop = w_pop + CNT_W'(valid_i[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retire <= '0;
        end else if (w_pass) begin
            r_retire <= r_retire + w_pop;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold <= '0;
        end else if (w_hold) begin
            if (r_hold != {HCNT_W{1'b1}})
                r_hold <= r_hold + HCNT_W'(1);
        end else begin
            r_hold <= '0;
        end
    end

    assign retire_cnt_o = r_retire;
    assign hold_cnt_o   = r_hold;

    // ascending scan so the highest-indexed matching lane wins
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_wr[i] && (r_addr[i] == fwd_addr_i) && (fwd_addr_i != '0)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = r_data[i];
            end
        end
    end

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Bench for wb_pipe_reg: vector table, directed hold/flush/wrap/reset sequences,
// then randomized traffic against a behavioural model of the stage.
module tb_wb_pipe_reg;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  stall;
    logic        flush;
    logic [1:0]  valid_i, rd_write_i;
    logic [4:0]  ia [2];
    logic [31:0] id [2];
    logic [9:0]  rd_addr_i;
    logic [63:0] rd_data_i;
    logic [1:0]  valid_o, rd_write_o;
    logic [9:0]  rd_addr_o;
    logic [63:0] rd_data_o;
    logic [4:0]  fwd_addr_i;
    logic        fwd_hit_o;
    logic [31:0] fwd_data_o;
    logic [CW-1:0] retire_cnt_o;
    logic [7:0]  hold_cnt_o;

    assign rd_addr_i = {ia[1], ia[0]};
    assign rd_data_i = {id[1], id[0]};

    always #5 clk = ~clk;

    wb_pipe_reg #(.LANES(2), .XLEN(32), .REG_ADDR_W(5), .STALL_W(2), .CNT_W(CW), .HCNT_W(8)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_i(valid_i), .rd_addr_i(rd_addr_i), .rd_write_i(rd_write_i), .rd_data_i(rd_data_i),
        .valid_o(valid_o), .rd_addr_o(rd_addr_o), .rd_write_o(rd_write_o), .rd_data_o(rd_data_o),
        .fwd_addr_i(fwd_addr_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
        .retire_cnt_o(retire_cnt_o), .hold_cnt_o(hold_cnt_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic apply(input logic [1:0] st, input logic fl, input logic [1:0] v, input logic [1:0] w,
                         input logic [4:0] a0, input logic [4:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [4:0] fa);
        stall = st; flush = fl; valid_i = v; rd_write_i = w;
        ia[0] = a0; ia[1] = a1; id[0] = d0; id[1] = d1; fwd_addr_i = fa;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: what the stage holds, plus the two counters as plain integers
    logic        mv [2];
    logic [4:0]  ma [2];
    logic        mw [2];
    logic [31:0] md [2];
    int          m_ret, m_hold;

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin mv[i] = 0; ma[i] = 0; mw[i] = 0; md[i] = 0; end
        m_ret = 0; m_hold = 0;
    endtask

    task automatic model_edge();
        if (!flush && stall == 2'b00) begin
            for (int i = 0; i < 2; i++) begin
                logic dead;
                dead = 1'b0;
                for (int j = i + 1; j < 2; j++)
                    if (valid_i[j] && rd_write_i[j] && ia[j] == ia[i]) dead = 1'b1;
                mv[i] = valid_i[i]; ma[i] = ia[i]; md[i] = id[i];
                mw[i] = valid_i[i] && rd_write_i[i] && (ia[i] != 0) && !dead;
            end
            m_ret  = (m_ret + $countones(valid_i)) % (1 << CW);
            m_hold = 0;
        end else if (!flush && stall == 2'b01) begin
            if (m_hold < 255) m_hold++;
        end else begin
            for (int i = 0; i < 2; i++) begin mv[i] = 0; ma[i] = 0; mw[i] = 0; md[i] = 0; end
            m_hold = 0;
        end
    endtask

    task automatic model_check();
        logic        h;
        logic [31:0] fd;
        h = 0; fd = 0;
        for (int i = 0; i < 2; i++)
            if (mw[i] && ma[i] == fwd_addr_i && fwd_addr_i != 0) begin h = 1; fd = md[i]; end
        chk("rnd_valid", valid_o, {mv[1], mv[0]});
        chk("rnd_addr",  rd_addr_o, {ma[1], ma[0]});
        chk("rnd_write", rd_write_o, {mw[1], mw[0]});
        chk("rnd_data",  rd_data_o, {md[1], md[0]});
        chk("rnd_hit",   fwd_hit_o, h);
        chk("rnd_fdata", fwd_data_o, fd);
        chk("rnd_ret",   retire_cnt_o, m_ret);
        chk("rnd_hold",  hold_cnt_o, m_hold);
    endtask

    typedef struct {
        logic [1:0]  st;
        logic        fl;
        logic [1:0]  v, w;
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
        logic [4:0]  fa;
        logic [1:0]  ev, ew;
        logic        eh;
        logic [31:0] ef;
        logic [CW-1:0] er;
        logic [7:0]  eho;
    } vec_t;

    vec_t tbl [10];

    task automatic do_reset();
        rst = 1'b0;
        apply(2'b00, 1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        //            st     fl  v      w      a0 a1 d0     d1     fa  ev     ew     eh  ef     er   hold
        tbl[0] = '{2'b00, 0, 2'b11, 2'b11, 5, 7, 32'h11, 32'h22, 7, 2'b11, 2'b11, 1, 32'h22, 2,  0};
        tbl[1] = '{2'b00, 0, 2'b11, 2'b11, 9, 9, 32'hA,  32'hB,  9, 2'b11, 2'b10, 1, 32'hB,  4,  0};
        tbl[2] = '{2'b00, 0, 2'b01, 2'b01, 0, 3, 32'h55, 32'h66, 0, 2'b01, 2'b00, 0, 32'h0,  5,  0};
        tbl[3] = '{2'b01, 0, 2'b11, 2'b11, 4, 4, 32'h1,  32'h2,  0, 2'b01, 2'b00, 0, 32'h0,  5,  1};
        tbl[4] = '{2'b00, 0, 2'b10, 2'b11, 6, 6, 32'h77, 32'h88, 6, 2'b10, 2'b10, 1, 32'h88, 6,  0};
        tbl[5] = '{2'b00, 0, 2'b11, 2'b01, 6, 6, 32'h77, 32'h88, 6, 2'b11, 2'b01, 1, 32'h77, 8,  0};
        tbl[6] = '{2'b01, 1, 2'b11, 2'b11, 6, 6, 32'h77, 32'h88, 6, 2'b00, 2'b00, 0, 32'h0,  8,  0};
        tbl[7] = '{2'b00, 0, 2'b11, 2'b11, 2, 3, 32'h12, 32'h13, 3, 2'b11, 2'b11, 1, 32'h13, 10, 0};
        tbl[8] = '{2'b11, 0, 2'b11, 2'b11, 2, 3, 32'h12, 32'h13, 3, 2'b00, 2'b00, 0, 32'h0,  10, 0};
        tbl[9] = '{2'b10, 0, 2'b11, 2'b11, 2, 3, 32'h12, 32'h13, 3, 2'b00, 2'b00, 0, 32'h0,  10, 0};

        do_reset();
        chk("rst_valid", valid_o, 0);
        chk("rst_write", rd_write_o, 0);
        chk("rst_data",  rd_data_o, 0);
        chk("rst_ret",   retire_cnt_o, 0);
        chk("rst_hold",  hold_cnt_o, 0);

        for (int k = 0; k < 10; k++) begin
            apply(tbl[k].st, tbl[k].fl, tbl[k].v, tbl[k].w, tbl[k].a0, tbl[k].a1, tbl[k].d0, tbl[k].d1, tbl[k].fa);
            step();
            chk($sformatf("vec%0d_valid", k), valid_o, tbl[k].ev);
            chk($sformatf("vec%0d_write", k), rd_write_o, tbl[k].ew);
            chk($sformatf("vec%0d_hit", k),   fwd_hit_o, tbl[k].eh);
            chk($sformatf("vec%0d_fdata", k), fwd_data_o, tbl[k].ef);
            chk($sformatf("vec%0d_ret", k),   retire_cnt_o, tbl[k].er);
            chk($sformatf("vec%0d_hold", k),  hold_cnt_o, tbl[k].eho);
        end

        // long hold: contents frozen while inputs churn, counter saturates
        do_reset();
        apply(2'b00, 0, 2'b01, 2'b01, 1, 0, 32'h33, 0, 1);
        step();
        for (int i = 0; i < 300; i++) begin
            apply(2'b01, 0, 2'($urandom), 2'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, 1);
            step();
            if (i == 9) chk("hold_cnt10", hold_cnt_o, 10);
        end
        chk("hold_data", rd_data_o[31:0], 32'h33);
        chk("hold_valid", valid_o, 2'b01);
        chk("hold_fwd", fwd_data_o, 32'h33);
        chk("hold_sat", hold_cnt_o, 255);
        apply(2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step();
        chk("hold_clear", hold_cnt_o, 0);

        // retire counter wrap: 7*2 + 1 = 15, then +2 wraps to 1
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(2'b00, 0, (i == 7) ? 2'b01 : 2'b11, 2'b00, 0, 0, 0, 0, 0);
            step();
        end
        chk("ret_max", retire_cnt_o, 15);
        apply(2'b00, 0, 2'b11, 2'b11, 4, 8, 32'hC0DE, 32'hBEEF, 8);
        step();
        chk("ret_wrap", retire_cnt_o, 1);

        // asynchronous reset in the middle of a cycle
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", valid_o, 0);
        chk("arst_write", rd_write_o, 0);
        chk("arst_data",  rd_data_o, 0);
        chk("arst_hit",   fwd_hit_o, 0);
        chk("arst_ret",   retire_cnt_o, 0);
        @(negedge clk);
        rst = 1'b1;
        apply(2'b00, 0, 2'b10, 2'b10, 0, 12, 0, 32'h99, 12);
        step();
        chk("resume_fdata", fwd_data_o, 32'h99);
        chk("resume_ret", retire_cnt_o, 1);

        // randomized traffic against the model
        do_reset();
        model_clear();
        for (int i = 0; i < 400; i++) begin
            logic [1:0] st;
            st = ($urandom_range(0, 9) < 5) ? 2'b00 : 2'($urandom);
            apply(st, ($urandom_range(0, 7) == 0), 2'($urandom), 2'($urandom),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom,
                  5'($urandom_range(0, 3)));
            model_edge();
            step();
            model_check();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
